uart_rx_8n1: RTL and testbench

Asynchronous serial receiver for the FPGA's USB-serial PMOD link. It oversamples the `rx` line with the system clock and deserialises 8N1 frames, LSB first. Each good byte goes out on `data_read` with a one-cycle `valid_byte` strobe. It also drives the PMOD's active-low RTS/CTS handshake lines and sits directly between the PMOD pins and the byte-consuming logic in `top`.

---
 rtl/uart_rx_8n1_if.sv | 28 ++
 rtl/uart_rx_8n1.sv | 158 +++++++++++++++
 tb/tb_uart_rx_8n1.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_8n1_if.sv
// Pin-side and byte-side signals of the 8N1 UART receiver.
// slave = receiver view, master = driver/consumer view.
interface uart_rx_8n1_if;
    logic       rx;
    logic       cts;
    logic       rts;
    logic [7:0] data_read;
    logic       valid_byte;
    logic       rx_error;

    modport slave (
        input  rx,
        output cts,
        output rts,
        output data_read,
        output valid_byte,
        output rx_error
    );

    modport master (
        output rx,
        input  cts,
        input  rts,
        input  data_read,
        input  valid_byte,
        input  rx_error
    );
endinterface

// File: rtl/uart_rx_8n1.sv
// Oversampling 8N1 UART receiver with active-low RTS/CTS outputs.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_rx_8n1 #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 115200
) (
    input  logic         clk,
    input  logic         reset,
    uart_rx_8n1_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;

    logic          sync_q;
    logic          rx_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          rts_q, rts_d;
    logic          cts_q;
    logic          bad_par;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    assign bad_par = par_q;
`else
    assign bad_par = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
`ifdef UART_RX_PARITY_EN
                par_d = 1'b0;
`endif
                // IDLE is only entered with rx_s high, so a low level is a fresh edge
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    par_d   = par_q ^ rx_s_q;
                    if (bit_q == 3'd7) state_d = S_PARITY;
`else
                    if (bit_q == 3'd7) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d   = '0;
                    par_d   = par_q ^ rx_s_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d = '0;
                    if (rx_s_q && !bad_par) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = rx_s_q ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        rts_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rts_q   <= 1'b1;
            cts_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            sync_q  <= bus.rx;
            rx_s_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rts_q   <= rts_d;
            cts_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.data_read  = data_q;
    assign bus.valid_byte = valid_q;
    assign bus.rx_error   = err_q;
    assign bus.rts        = rts_q;
    assign bus.cts        = cts_q;
endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: frame-level model of sent bytes
// compared against the bytes and error pulses the receiver reports.
module tb_uart_rx_8n1;
    logic clk = 1'b0;
    logic reset;

    uart_rx_8n1_if bus();

    uart_rx_8n1 #(
        .CLK_FREQ(12_000_000),
        .BAUD(115200)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int BITP = 104;

    int checks = 0;
    int failures = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            if (bus.valid_byte) begin
                obs_q.push_back(bus.data_read);
                vld_cnt <= vld_cnt + 1;
            end
            if (bus.rx_error) err_cnt <= err_cnt + 1;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic par_flip, input int per);
        logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop, (^b) ^ par_flip, b, 1'b0};
`else
        bits = {1'b1, stop, b, 1'b0};
`endif
        for (int i = 0; i < NBITS; i++) begin
            bus.rx = bits[i];
            repeat (per) @(negedge clk);
        end
        if (stop && !par_flip) begin
            exp_q.push_back(b);
            last_good = b;
        end
    endtask

    task automatic compare_queues(input string name);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL %s byte%0d: got %02h want %02h", name, i, obs_q[i], exp_q[i]);
                end
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset;
        bus.rx = 1'b1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks += 4;
        if (bus.rts !== 1'b1) begin failures++; $display("FAIL rst_rts: got %b want 1", bus.rts); end
        if (bus.cts !== 1'b1) begin failures++; $display("FAIL rst_cts: got %b want 1", bus.cts); end
        if (bus.data_read !== 8'h00) begin failures++; $display("FAIL rst_data: got %02h want 00", bus.data_read); end
        if (bus.valid_byte !== 1'b0 || bus.rx_error !== 1'b0) begin
            failures++; $display("FAIL rst_strobe: got %b%b want 00", bus.valid_byte, bus.rx_error);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 3;
        if (bus.rts !== 1'b0) begin failures++; $display("FAIL run_rts: got %b want 0", bus.rts); end
        if (bus.cts !== 1'b0) begin failures++; $display("FAIL run_cts: got %b want 0", bus.cts); end
        if (bus.data_read !== 8'h00) begin failures++; $display("FAIL run_data: got %02h want 00", bus.data_read); end
    endtask

    task automatic test_latency;
        int lat;
        lat = 2 + 52 + (NBITS - 1) * BITP;
        @(negedge clk);
        fork
            send_frame(8'hA5, 1'b1, 1'b0, BITP);
            begin
                repeat (lat) @(posedge clk);
                @(negedge clk);
                checks++;
                if (bus.valid_byte !== 1'b0) begin failures++; $display("FAIL lat_early: got %b want 0", bus.valid_byte); end
                @(posedge clk);
                @(negedge clk);
                checks += 2;
                if (bus.valid_byte !== 1'b1) begin failures++; $display("FAIL lat_pulse: got %b want 1", bus.valid_byte); end
                if (bus.data_read !== 8'hA5) begin failures++; $display("FAIL lat_data: got %02h want a5", bus.data_read); end
                @(negedge clk);
                checks += 2;
                if (bus.valid_byte !== 1'b0) begin failures++; $display("FAIL lat_width: got %b want 0", bus.valid_byte); end
                if (bus.data_read !== 8'hA5) begin failures++; $display("FAIL lat_hold: got %02h want a5", bus.data_read); end
            end
        join
        bus.rx = 1'b1;
        repeat (50) @(negedge clk);
        compare_queues("latency");
    endtask

    task automatic test_back_to_back;
        send_frame(8'h00, 1'b1, 1'b0, BITP);
        send_frame(8'hFF, 1'b1, 1'b0, BITP);
        send_frame(8'h81, 1'b1, 1'b0, BITP);
        bus.rx = 1'b1;
        repeat (200) @(negedge clk);
        compare_queues("b2b");
    endtask

    task automatic test_glitch;
        int v0;
        int e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        bus.rx = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.rts !== 1'b1) begin failures++; $display("FAIL glitch_busy: got %b want 1", bus.rts); end
        repeat (10) @(negedge clk);
        bus.rx = 1'b1;
        repeat (150) @(negedge clk);
        checks += 2;
        if (vld_cnt !== v0 || err_cnt !== e0) begin
            failures++; $display("FAIL glitch_strobe: got v%0d e%0d want v%0d e%0d", vld_cnt, err_cnt, v0, e0);
        end
        if (bus.rts !== 1'b0) begin failures++; $display("FAIL glitch_rts: got %b want 0", bus.rts); end
    endtask

    task automatic test_break;
        int v0;
        int e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, BITP);
        bus.rx = 1'b0;
        repeat (500) @(negedge clk);
        checks += 4;
        if (err_cnt !== e0 + 1) begin failures++; $display("FAIL brk_err: got %0d want %0d", err_cnt, e0 + 1); end
        if (vld_cnt !== v0) begin failures++; $display("FAIL brk_valid: got %0d want %0d", vld_cnt, v0); end
        if (bus.data_read !== last_good) begin
            failures++; $display("FAIL brk_data: got %02h want %02h", bus.data_read, last_good);
        end
        if (bus.rts !== 1'b1) begin failures++; $display("FAIL brk_rts: got %b want 1", bus.rts); end
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.rts !== 1'b0) begin failures++; $display("FAIL brk_idle: got %b want 0", bus.rts); end
        send_frame(8'h3C, 1'b1, 1'b0, BITP);
        bus.rx = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (err_cnt !== e0 + 1) begin failures++; $display("FAIL brk_err2: got %0d want %0d", err_cnt, e0 + 1); end
        compare_queues("break");
    endtask

    task automatic test_midframe_reset;
        int v0;
        v0 = vld_cnt;
        bus.rx = 1'b0;
        repeat (BITP) @(negedge clk);
        bus.rx = 1'b1;
        repeat (300) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks += 2;
        if (bus.rts !== 1'b1) begin failures++; $display("FAIL mid_rts: got %b want 1", bus.rts); end
        if (bus.data_read !== 8'h00) begin failures++; $display("FAIL mid_data: got %02h want 00", bus.data_read); end
        last_good = 8'h00;
        reset = 1'b1;
        repeat (BITP * NBITS) @(negedge clk);
        checks += 2;
        if (vld_cnt !== v0) begin failures++; $display("FAIL mid_strobe: got %0d want %0d", vld_cnt, v0); end
        if (bus.rts !== 1'b0) begin failures++; $display("FAIL mid_idle: got %b want 0", bus.rts); end
        send_frame(8'h5A, 1'b1, 1'b0, BITP);
        bus.rx = 1'b1;
        repeat (100) @(negedge clk);
        compare_queues("midreset");
    endtask

    task automatic test_random;
        logic [7:0] b;
        int per;
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            per = $urandom_range(102, 106);
            send_frame(b, 1'b1, 1'b0, per);
            bus.rx = 1'b1;
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        repeat (200) @(negedge clk);
        compare_queues("random");
        checks++;
        if (bus.data_read !== last_good) begin
            failures++; $display("FAIL rnd_hold: got %02h want %02h", bus.data_read, last_good);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int e0;
        int v0;
        e0 = err_cnt;
        send_frame(8'h07, 1'b1, 1'b0, BITP);
        bus.rx = 1'b1;
        repeat (100) @(negedge clk);
        compare_queues("par_good");
        v0 = vld_cnt;
        send_frame(8'h07, 1'b1, 1'b1, BITP);
        bus.rx = 1'b1;
        repeat (100) @(negedge clk);
        checks += 3;
        if (err_cnt !== e0 + 1) begin failures++; $display("FAIL par_err: got %0d want %0d", err_cnt, e0 + 1); end
        if (vld_cnt !== v0) begin failures++; $display("FAIL par_valid: got %0d want %0d", vld_cnt, v0); end
        if (bus.data_read !== 8'h07) begin failures++; $display("FAIL par_data: got %02h want 07", bus.data_read); end
        compare_queues("par_bad");
    endtask
`endif

    initial begin
        reset = 1'b0;
        bus.rx = 1'b1;
        test_reset();
        test_latency();
        test_back_to_back();
        test_glitch();
        test_break();
        test_midframe_reset();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
